// File: rtl/hn_data_ctrl.sv
// Load/play sequencer for the Hn data buffer: writes a frame of host nibbles into
// the RAM write port, then replays it bit by bit as a paced serial stream.
module hn_data_ctrl #(
    parameter int NIB_NUM = 256,
    parameter int BIT_NUM = 1024,
    parameter int BIT_CYC = 4
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       cfg_clr,
    input  logic       din_valid,
    input  logic [3:0] din,
    output logic       din_ready,
    output logic       load_done,
    input  logic       play_start,
    output logic       play_busy,
    output logic       play_done,
    output logic       ram_wren,
    output logic [9:0] ram_wraddress,
    output logic [3:0] ram_wdata,
    output logic       ram_rden,
    output logic [9:0] ram_rdaddress,
    input  logic       ram_q,
    output logic       ser_data,
    output logic       ser_stb,
    output logic       ser_last
);

    // state    | meaning
    // S_IDLE   | empty buffer, waiting for the first nibble
    // S_LOAD   | frame partially written
    // S_LOADED | frame complete, waiting for play_start
    // S_PLAY   | reading and serialising the frame
    // S_DONE   | one-clock play_done, then back to S_LOADED
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_LOADED, S_PLAY, S_DONE} state_t;

    localparam int CW = $clog2(BIT_CYC);
    localparam int TW = $clog2(BIT_CYC + 1);
    localparam logic [8:0]    NIB_LAST  = 9'(NIB_NUM - 1);
    localparam logic [10:0]   BIT_LAST  = 11'(BIT_NUM - 1);
    localparam logic [10:0]   BIT_END   = 11'(BIT_NUM);
    localparam logic [CW-1:0] CNT_LAST  = CW'(BIT_CYC - 1);
    localparam logic [TW-1:0] TAIL_INIT = TW'(BIT_CYC - 1);

    state_t        state_q, state_d;
    logic [8:0]    wr_ptr_q, wr_ptr_d;
    logic [10:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [TW-1:0] tail_q, tail_d;
    logic          q_vld_q, q_vld_d;
    logic          q_last_q, q_last_d;
    logic          din_ready_q, din_ready_d;
    logic          load_done_q, load_done_d;
    logic          play_busy_q, play_busy_d;
    logic          play_done_q, play_done_d;
    logic          ram_wren_q, ram_wren_d;
    logic [9:0]    ram_wraddress_q, ram_wraddress_d;
    logic [3:0]    ram_wdata_q, ram_wdata_d;
    logic          ram_rden_q, ram_rden_d;
    logic [9:0]    ram_rdaddress_q, ram_rdaddress_d;
    logic          ser_data_q, ser_data_d;
    logic          ser_stb_q, ser_stb_d;
    logic          ser_last_q, ser_last_d;

    logic accept, wr_last;

    assign accept  = din_valid & din_ready_q;
    assign wr_last = accept & (wr_ptr_q == NIB_LAST);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (cfg_clr) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:   if (accept) state_d = wr_last ? S_LOADED : S_LOAD;
                S_LOAD:   if (wr_last) state_d = S_LOADED;
                S_LOADED: if (play_start) state_d = S_PLAY;
                S_PLAY:   if (tail_q == TW'(1)) state_d = S_DONE;
                S_DONE:   state_d = S_LOADED;
                default:  state_d = S_IDLE;
            endcase
        end
    end

    // Pointers, bit pacing and the read pipeline. The tail counter times the last
    // serial bit out, since the read side finishes two clocks ahead of ser_stb.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        tail_d   = '0;
        q_vld_d  = ram_rden_q & ~cfg_clr;
        q_last_d = ram_rden_q & (ram_rdaddress_q == BIT_LAST[9:0]) & ~cfg_clr;
        if (cfg_clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (accept) wr_ptr_d = wr_ptr_q + 9'd1;
            if (state_q == S_LOADED && play_start) begin
                rd_ptr_d = '0;
                cnt_d    = '0;
            end else if (state_q == S_PLAY) begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (rd_ptr_q != BIT_END) rd_ptr_d = rd_ptr_q + 11'd1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
                if (ser_stb_q && ser_last_q) tail_d = TAIL_INIT;
                else if (tail_q != '0)       tail_d = tail_q - TW'(1);
            end
        end
    end

    always_comb begin
        din_ready_d     = (state_d == S_IDLE) || (state_d == S_LOAD);
        load_done_d     = (state_d == S_LOADED) || (state_d == S_PLAY) || (state_d == S_DONE);
        play_busy_d     = (state_d == S_PLAY);
        play_done_d     = (state_d == S_DONE);
        ram_wren_d      = accept & ~cfg_clr;
        ram_wraddress_d = ram_wraddress_q;
        ram_wdata_d     = ram_wdata_q;
        if (accept && !cfg_clr) begin
            ram_wraddress_d = {2'b00, wr_ptr_q[7:0]};
            ram_wdata_d     = din;
        end
        ram_rden_d      = ~cfg_clr && (state_q == S_PLAY) && (cnt_q == '0) && (rd_ptr_q != BIT_END);
        ram_rdaddress_d = ram_rden_d ? rd_ptr_q[9:0] : ram_rdaddress_q;
        ser_stb_d       = q_vld_q & ~cfg_clr;
        ser_last_d      = q_last_q & ~cfg_clr;
        if (cfg_clr || state_d != S_PLAY) ser_data_d = 1'b0;
        else if (q_vld_q)                 ser_data_d = ram_q;
        else                              ser_data_d = ser_data_q;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            cnt_q           <= '0;
            tail_q          <= '0;
            q_vld_q         <= 1'b0;
            q_last_q        <= 1'b0;
            din_ready_q     <= 1'b1;
            load_done_q     <= 1'b0;
            play_busy_q     <= 1'b0;
            play_done_q     <= 1'b0;
            ram_wren_q      <= 1'b0;
            ram_wraddress_q <= '0;
            ram_wdata_q     <= '0;
            ram_rden_q      <= 1'b0;
            ram_rdaddress_q <= '0;
            ser_data_q      <= 1'b0;
            ser_stb_q       <= 1'b0;
            ser_last_q      <= 1'b0;
        end else begin
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            cnt_q           <= cnt_d;
            tail_q          <= tail_d;
            q_vld_q         <= q_vld_d;
            q_last_q        <= q_last_d;
            din_ready_q     <= din_ready_d;
            load_done_q     <= load_done_d;
            play_busy_q     <= play_busy_d;
            play_done_q     <= play_done_d;
            ram_wren_q      <= ram_wren_d;
            ram_wraddress_q <= ram_wraddress_d;
            ram_wdata_q     <= ram_wdata_d;
            ram_rden_q      <= ram_rden_d;
            ram_rdaddress_q <= ram_rdaddress_d;
            ser_data_q      <= ser_data_d;
            ser_stb_q       <= ser_stb_d;
            ser_last_q      <= ser_last_d;
        end
    end

    assign din_ready     = din_ready_q;
    assign load_done     = load_done_q;
    assign play_busy     = play_busy_q;
    assign play_done     = play_done_q;
    assign ram_wren      = ram_wren_q;
    assign ram_wraddress = ram_wraddress_q;
    assign ram_wdata     = ram_wdata_q;
    assign ram_rden      = ram_rden_q;
    assign ram_rdaddress = ram_rdaddress_q;
    assign ser_data      = ser_data_q;
    assign ser_stb       = ser_stb_q;
    assign ser_last      = ser_last_q;

endmodule

// File: tb/tb_hn_data_ctrl.sv
// Directed bench for hn_data_ctrl with a 1-clock-latency dual-port RAM model.
module tb_hn_data_ctrl;

    localparam int NIB = 256;
    localparam int NBIT = 1024;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       cfg_clr = 1'b0;
    logic       din_valid = 1'b0;
    logic [3:0] din = 4'h0;
    logic       din_ready, load_done;
    logic       play_start = 1'b0;
    logic       play_busy, play_done;
    logic       ram_wren, ram_rden;
    logic [9:0] ram_wraddress, ram_rdaddress;
    logic [3:0] ram_wdata;
    logic       ram_q = 1'b0;
    logic       ser_data, ser_stb, ser_last;

    hn_data_ctrl #(.NIB_NUM(NIB), .BIT_NUM(NBIT), .BIT_CYC(4)) dut (
        .clk(clk), .rstn(rstn), .cfg_clr(cfg_clr),
        .din_valid(din_valid), .din(din), .din_ready(din_ready), .load_done(load_done),
        .play_start(play_start), .play_busy(play_busy), .play_done(play_done),
        .ram_wren(ram_wren), .ram_wraddress(ram_wraddress), .ram_wdata(ram_wdata),
        .ram_rden(ram_rden), .ram_rdaddress(ram_rdaddress), .ram_q(ram_q),
        .ser_data(ser_data), .ser_stb(ser_stb), .ser_last(ser_last)
    );

    always #5 clk = ~clk;

    logic [3:0] mem [256];
    always @(posedge clk) begin
        if (ram_wren) mem[ram_wraddress[7:0]] <= ram_wdata;
        if (ram_rden) ram_q <= mem[ram_rdaddress[9:2]][ram_rdaddress[1:0]];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Pattern and write base are owned by the stimulus; the monitor only reads them.
    logic [3:0] pat = 4'h0;
    int         wr_base = 0;
    logic [7:0] ea;

    int wr_cnt = 0, wr_bad = 0, stb_cnt = 0, gap_bad = 0, data_bad = 0;
    int last_cnt = 0, last_bad = 0, hold_bad = 0, rden_cnt = 0, done_cnt = 0;
    int idx = 0, first_stb_cyc = 0, last_stb_cyc = 0, done_cyc = 0;
    logic held = 1'b0, busy_prev = 1'b0;

    assign ea = 8'(wr_cnt - wr_base);

    function automatic logic exp_bit(input int k, input logic [3:0] p);
        logic [9:0] a;
        logic [3:0] nib;
        a   = 10'(k);
        nib = a[5:2] ^ p;
        return nib[a[1:0]];
    endfunction

    always @(negedge clk) begin
        busy_prev <= play_busy;
        if (play_busy && !busy_prev) begin
            idx  <= 0;
            held <= 1'b0;
        end
        if (ram_wren) begin
            wr_cnt <= wr_cnt + 1;
            if (ram_wraddress !== {2'b00, ea} || ram_wdata !== (ea[3:0] ^ pat)) wr_bad <= wr_bad + 1;
        end
        if (ser_stb) begin
            stb_cnt      <= stb_cnt + 1;
            idx          <= idx + 1;
            last_stb_cyc <= cyc;
            held         <= ser_data;
            if (idx == 0) first_stb_cyc <= cyc;
            else if (cyc - last_stb_cyc != 4) gap_bad <= gap_bad + 1;
            if (ser_data !== exp_bit(idx, pat)) data_bad <= data_bad + 1;
            if (ser_last !== (idx == NBIT - 1)) last_bad <= last_bad + 1;
            if (ser_last) last_cnt <= last_cnt + 1;
        end else begin
            if (play_busy && busy_prev && ser_data !== held) hold_bad <= hold_bad + 1;
            if (ser_last) last_bad <= last_bad + 1;
        end
        if (ram_rden) rden_cnt <= rden_cnt + 1;
        if (play_done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
    end

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_frame(input logic [3:0] p, input int start_at, input bit clr_last);
        int  i, k;
        bit  acc;
        pat     = p;
        wr_base = wr_cnt;
        i = 0;
        k = 0;
        while (i < NIB && k < 2000) begin
            play_start = (k == start_at);
            if (k % 3 == 2) din_valid = 1'b0;
            else begin
                din_valid = 1'b1;
                din       = 4'(i) ^ p;
            end
            acc = din_valid && din_ready;
            if (acc && i == NIB - 1) begin
                chk("load_done_before_last", load_done, 0);
                if (clr_last) cfg_clr = 1'b1;
            end
            step();
            play_start = 1'b0;
            cfg_clr    = 1'b0;
            if (acc) i++;
            k++;
        end
        din_valid = 1'b0;
        chk("load_accept_count", i, NIB);
    endtask

    task automatic play_full(input int illegal_at);
        int s_stb, s_rden, s_done, s_last, t0, n;
        bit fin;
        s_stb  = stb_cnt;
        s_rden = rden_cnt;
        s_done = done_cnt;
        s_last = last_cnt;
        play_start = 1'b1;
        step();
        play_start = 1'b0;
        t0 = cyc;
        chk("play_busy_rise", play_busy, 1);
        fin = 1'b0;
        n   = 0;
        while (!fin && n < 6000) begin
            if (n == illegal_at) play_start = 1'b1;
            if (play_done) fin = 1'b1;
            step();
            play_start = 1'b0;
            n++;
        end
        chk("play_done_seen", fin, 1);
        chk("first_stb_latency", first_stb_cyc - t0, 3);
        chk("stb_count", stb_cnt - s_stb, NBIT);
        chk("rden_count", rden_cnt - s_rden, NBIT);
        chk("last_count", last_cnt - s_last, 1);
        chk("done_count", done_cnt - s_done, 1);
        chk("done_after_last_stb", done_cyc - last_stb_cyc, 4);
        chk("stb_gap_errors", gap_bad, 0);
        chk("ser_data_errors", data_bad, 0);
        chk("ser_last_errors", last_bad, 0);
        chk("ser_hold_errors", hold_bad, 0);
        chk("busy_after_play", play_busy, 0);
        chk("load_done_kept", load_done, 1);
        chk("ready_after_play", din_ready, 0);
    endtask

    initial begin
        int w0, r0, s0, d0, nb, n;
        bit hit;

        rstn       = 1'b0;
        din_valid  = 1'b1;
        din        = 4'h5;
        play_start = 1'b1;
        repeat (3) step();
        chk("rst_din_ready", din_ready, 1);
        chk("rst_load_done", load_done, 0);
        chk("rst_play_busy", play_busy, 0);
        chk("rst_play_done", play_done, 0);
        chk("rst_ram_wren", ram_wren, 0);
        chk("rst_ram_wraddress", ram_wraddress, 0);
        chk("rst_ram_wdata", ram_wdata, 0);
        chk("rst_ram_rden", ram_rden, 0);
        chk("rst_ram_rdaddress", ram_rdaddress, 0);
        chk("rst_ser_data", ser_data, 0);
        chk("rst_ser_stb", ser_stb, 0);
        chk("rst_ser_last", ser_last, 0);
        din_valid  = 1'b0;
        play_start = 1'b0;
        rstn       = 1'b1;
        w0 = wr_cnt;
        repeat (3) step();
        chk("no_write_after_reset", wr_cnt - w0, 0);

        play_start = 1'b1;
        step();
        play_start = 1'b0;
        r0 = rden_cnt;
        repeat (4) step();
        chk("idle_start_busy", play_busy, 0);
        chk("idle_start_ready", din_ready, 1);
        chk("idle_start_rden", rden_cnt - r0, 0);

        r0 = rden_cnt;
        load_frame(4'h0, 150, 1'b0);
        chk("load_done_rise", load_done, 1);
        chk("ready_drop", din_ready, 0);
        step();
        chk("write_count", wr_cnt - wr_base, NIB);
        chk("write_errors", wr_bad, 0);
        chk("load_start_rden", rden_cnt - r0, 0);
        chk("load_start_busy", play_busy, 0);

        w0 = wr_cnt;
        din_valid = 1'b1;
        repeat (3) step();
        din_valid = 1'b0;
        step();
        chk("loaded_ignores_din", wr_cnt - w0, 0);

        play_full(500);
        play_full(-1);

        s0 = stb_cnt;
        d0 = done_cnt;
        play_start = 1'b1;
        step();
        play_start = 1'b0;
        nb  = 0;
        n   = 0;
        hit = 1'b0;
        while (!hit && n < 2000) begin
            if (ser_stb) begin
                if (nb == 100) begin
                    cfg_clr = 1'b1;
                    hit     = 1'b1;
                end
                nb++;
            end
            step();
            n++;
        end
        cfg_clr = 1'b0;
        chk("abort_reached", hit, 1);
        chk("abort_ready", din_ready, 1);
        chk("abort_ser_data", ser_data, 0);
        chk("abort_busy", play_busy, 0);
        chk("abort_load_done", load_done, 0);
        chk("abort_stb", ser_stb, 0);
        repeat (10) step();
        chk("abort_stb_count", stb_cnt - s0, 101);
        chk("abort_no_done", done_cnt - d0, 0);

        load_frame(4'hA, -1, 1'b0);
        step();
        chk("reload_write_count", wr_cnt - wr_base, NIB);
        chk("reload_write_errors", wr_bad, 0);
        play_full(-1);

        cfg_clr = 1'b1;
        step();
        cfg_clr = 1'b0;
        load_frame(4'h5, -1, 1'b1);
        chk("clr_last_load_done", load_done, 0);
        chk("clr_last_ready", din_ready, 1);
        step();
        chk("clr_last_write_count", wr_cnt - wr_base, NIB - 1);

        load_frame(4'h3, -1, 1'b0);
        chk("clr_start_loaded", load_done, 1);
        r0 = rden_cnt;
        play_start = 1'b1;
        cfg_clr    = 1'b1;
        step();
        play_start = 1'b0;
        cfg_clr    = 1'b0;
        repeat (4) step();
        chk("clr_start_busy", play_busy, 0);
        chk("clr_start_ready", din_ready, 1);
        chk("clr_start_rden", rden_cnt - r0, 0);

        din_valid = 1'b1;
        din       = 4'h7;
        repeat (3) step();
        rstn = 1'b0;
        #1;
        chk("midrst_wren", ram_wren, 0);
        chk("midrst_wraddress", ram_wraddress, 0);
        chk("midrst_ready", din_ready, 1);
        din_valid = 1'b0;
        rstn      = 1'b1;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
